// File: rtl/uart_pkg.sv
// Shared UART constants: receiver FSM state codes, 8N1 framing and the ASCII set the calculator uses.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_R     = 8'h52;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk latency, no backpressure.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: ready pulses 9.5 bit-times + 2..3 clk after the start edge on rx.
// No backpressure: every ready/frame_err pulse is a single cycle and must be consumed.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       ready,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST      = 3'(DATA_BITS - 1);

  logic             w_rxs;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_ready;
  logic             r_frame_err;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (rx),
    .o_q   (w_rxs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        // Re-check the start bit at its centre so short glitches are rejected.
        ST_START: begin
          if (r_cnt == CNT_HALF_LAST) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= ST_IDLE;
            end else begin
              r_bit_idx <= '0;
              r_state   <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == CNT_BIT_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rxs;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == CNT_BIT_LAST) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_data  <= r_shift;
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A line held low after a bad stop bit must not be taken as new start bits.
        ST_BREAK: begin
          if (w_rxs) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign ready     = r_ready;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clk/bit: directed cases plus randomized frames vs a byte-level model.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CLK_NS = 10;
  localparam int BIT_NS = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       ready;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] rdy_q[$];
  int         rdy_cyc[$];
  int         ferr_cnt = 0;
  int         overlap_cnt = 0;
  int         long_cnt = 0;
  logic       prev_rdy = 1'b0;
  logic       prev_ferr = 1'b0;

  uart_rx_byte #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .ready     (ready),
    .frame_err (frame_err)
  );

  always #(CLK_NS/2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready) begin
      rdy_q.push_back(rx_data);
      rdy_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (ready && frame_err) overlap_cnt++;
    if ((ready && prev_rdy) || (frame_err && prev_ferr)) long_cnt++;
    prev_rdy  = ready;
    prev_ferr = frame_err;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rdy_q.delete();
    rdy_cyc.delete();
    ferr_cnt = 0;
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  // Drives one 8N1 frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(per);
    end
    rx = stop;
    #(per);
  endtask

  logic [7:0] msg [5];
  logic [7:0] pool [10];
  logic [7:0] exp_q[$];
  logic [7:0] model_last;
  logic [7:0] b;
  int         start_cyc;
  int         lat;
  int         per;
  int         exp_ferr;
  logic       good;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready", ready, 1'b0);
    check_val("rst_ferr", frame_err, 1'b0);
    check_val("rst_data", rx_data, 8'h00);
    check_val("rst_state", dut.r_state, ST_IDLE);

    // Single good frame and its latency from the start edge.
    clear_log();
    align();
    start_cyc = cyc;
    send_frame(digit_char(4'd3), 1'b1, BIT_NS);
    #(2*BIT_NS);
    check_val("t1_count", rdy_q.size(), 1);
    check_val("t1_ferr", ferr_cnt, 0);
    if (rdy_q.size() == 1) begin
      check_val("t1_data", rdy_q[0], 8'h33);
      lat = rdy_cyc[0] - start_cyc;
      check_val("t1_latency_154pm3", (lat >= 151 && lat <= 157), 1'b1);
    end

    // Bad stop bit, then the line stays low for three bit-times.
    clear_log();
    align();
    send_frame(CH_A, 1'b0, BIT_NS);
    #(3*BIT_NS);
    check_val("t3_ferr", ferr_cnt, 1);
    check_val("t3_noready", rdy_q.size(), 0);
    check_val("t3_hold_data", rx_data, 8'h33);
    rx = 1'b1;
    #(2*BIT_NS);
    send_frame(CH_EQ, 1'b1, BIT_NS);
    #(2*BIT_NS);
    check_val("t3_ferr_after", ferr_cnt, 1);
    check_val("t3_count", rdy_q.size(), 1);
    check_val("t3_data", rx_data, 8'h3D);

    // Glitch shorter than half a bit.
    clear_log();
    align();
    rx = 1'b0;
    #(5*CLK_NS);
    rx = 1'b1;
    #(2*BIT_NS);
    check_val("t2_noready", rdy_q.size(), 0);
    check_val("t2_noferr", ferr_cnt, 0);
    check_val("t2_idle", dut.r_state, ST_IDLE);
    send_frame(CH_PLUS, 1'b1, BIT_NS);
    #(2*BIT_NS);
    check_val("t2_count", rdy_q.size(), 1);
    check_val("t2_data", rx_data, 8'h2B);

    // "12+5=" with no idle gap between frames.
    clear_log();
    msg[0] = digit_char(4'd1);
    msg[1] = digit_char(4'd2);
    msg[2] = CH_PLUS;
    msg[3] = digit_char(4'd5);
    msg[4] = CH_EQ;
    align();
    for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1, BIT_NS);
    #(2*BIT_NS);
    check_val("t4_count", rdy_q.size(), 5);
    if (rdy_q.size() == 5) begin
      check_val("t4_d0", rdy_q[0], 8'h31);
      check_val("t4_d1", rdy_q[1], 8'h32);
      check_val("t4_d2", rdy_q[2], 8'h2B);
      check_val("t4_d3", rdy_q[3], 8'h35);
      check_val("t4_d4", rdy_q[4], 8'h3D);
    end

    // Reset during data bit 3; the host abandons the frame, so the line idles high.
    clear_log();
    align();
    b = CH_R;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[3];
    #(BIT_NS/2);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t5_rst_ready", ready, 1'b0);
    check_val("t5_rst_data", rx_data, 8'h00);
    #(12*BIT_NS);
    check_val("t5_no_pulse", rdy_q.size() + ferr_cnt, 0);
    align();
    send_frame(CH_R, 1'b1, BIT_NS);
    #(2*BIT_NS);
    check_val("t5_count", rdy_q.size(), 1);
    check_val("t5_data", rx_data, 8'h52);

    // +3% and -3% bit periods.
    clear_log();
    align();
    send_frame(8'h55, 1'b1, 165);
    #(2*165);
    send_frame(8'hAA, 1'b1, 155);
    #(2*155);
    check_val("t6_count", rdy_q.size(), 2);
    check_val("t6_ferr", ferr_cnt, 0);
    if (rdy_q.size() == 2) begin
      check_val("t6_d55", rdy_q[0], 8'h55);
      check_val("t6_dAA", rdy_q[1], 8'hAA);
    end

    // Randomized frames: mixed bytes, bit periods, gaps and occasional bad stop bits.
    clear_log();
    pool[0] = CH_0;     pool[1] = CH_9; pool[2] = CH_PLUS; pool[3] = CH_MINUS;
    pool[4] = CH_EQ;    pool[5] = CH_A; pool[6] = CH_O;    pool[7] = CH_C;
    pool[8] = CH_R;     pool[9] = 8'h00;
    exp_ferr   = 0;
    model_last = 8'hAA;
    align();
    for (int n = 0; n < 24; n++) begin
      b    = ($urandom_range(1) == 0) ? pool[$urandom_range(9)] : 8'($urandom);
      per  = 155 + 5 * int'($urandom_range(2));
      good = ($urandom_range(5) != 0);
      send_frame(b, good, per);
      if (good) begin
        exp_q.push_back(b);
        model_last = b;
      end else begin
        exp_ferr++;
        #(per);
        rx = 1'b1;
        #(per);
      end
      #(per * int'($urandom_range(2)));
    end
    #(3*BIT_NS);
    check_val("rnd_count", rdy_q.size(), exp_q.size());
    check_val("rnd_ferr", ferr_cnt, exp_ferr);
    for (int i = 0; i < exp_q.size() && i < rdy_q.size(); i++)
      check_val($sformatf("rnd_d%0d", i), rdy_q[i], exp_q[i]);
    check_val("rnd_last", rx_data, model_last);

    check_val("never_both", overlap_cnt, 0);
    check_val("single_cycle", long_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
